// File: rtl/text_window_scroller.sv
// Text window scroller: reads the message ROM one character per clock,
// stages a NUM_DIGITS-wide window and commits it atomically, advancing the
// window start by one position every STEP_CYCLES clocks with wrap at MSG_LEN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | window stable, divider counting toward the next step
// FETCH  | one ROM read per clock into the staging buffer
// COMMIT | staging copied to window, pos advanced, step_done pulsed
module text_window_scroller #(
    parameter int MSG_LEN     = 12,
    parameter int NUM_DIGITS  = 4,
    parameter int STEP_CYCLES = 25000000,
    parameter int ADDR_W      = 4,
    parameter int CODE_W      = 4,
    parameter int RESET_CODE  = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         restart,
    input  logic [CODE_W-1:0]            char_code,
    output logic [ADDR_W-1:0]            rom_addr,
    output logic [NUM_DIGITS*CODE_W-1:0] window,
    output logic                         window_valid,
    output logic                         busy,
    output logic                         step_done
);

    localparam int DIV_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MSG_LEN - 1);
    localparam logic [NUM_DIGITS*CODE_W-1:0] WINDOW_RESET =
        {NUM_DIGITS{CODE_W'(RESET_CODE)}};

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMMIT} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               pos_q, pos_d;
    logic [ADDR_W-1:0]               rom_addr_q, rom_addr_d;
    logic [DIV_W-1:0]                div_q, div_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            init_pending_q, init_pending_d;
    logic [CODE_W-1:0]               staging_q [NUM_DIGITS];
    logic [CODE_W-1:0]               staging_d [NUM_DIGITS];
    logic [NUM_DIGITS*CODE_W-1:0]    window_q, window_d;
    logic                            window_valid_q, window_valid_d;
    logic                            step_done_q, step_done_d;
    logic                            trigger;

    // Modular increment; all address arithmetic stays inside 0..MSG_LEN-1.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + ADDR_W'(1);
    endfunction

    assign trigger = (state_q == S_IDLE) && en && (init_pending_q || (div_q == DIV_LAST));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; restart forces IDLE from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (trigger) state_d = S_FETCH;
            S_FETCH:  if (idx_q == IDX_LAST) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (restart) state_d = S_IDLE;
    end

    // Datapath next values: divider, fetch addressing, staging and commit.
    always_comb begin
        pos_d          = pos_q;
        rom_addr_d     = rom_addr_q;
        div_d          = div_q;
        idx_d          = idx_q;
        init_pending_d = init_pending_q;
        staging_d      = staging_q;
        window_d       = window_q;
        window_valid_d = window_valid_q;
        step_done_d    = 1'b0;

        // Divider parks at its last value if a step is due while not IDLE,
        // so the step is taken as soon as the machine returns to IDLE.
        if (trigger) begin
            div_d = '0;
        end else if (en && (div_q != DIV_LAST)) begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    idx_d          = '0;
                    rom_addr_d     = pos_q;
                    init_pending_d = 1'b0;
                end
            end
            S_FETCH: begin
                staging_d[idx_q] = char_code;
                rom_addr_d       = addr_inc(rom_addr_q);
                idx_d            = idx_q + IDX_W'(1);
            end
            S_COMMIT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    window_d[(NUM_DIGITS-1-i)*CODE_W +: CODE_W] = staging_q[i];
                end
                window_valid_d = 1'b1;
                step_done_d    = 1'b1;
                pos_d          = addr_inc(pos_q);
                rom_addr_d     = addr_inc(pos_q);
            end
            default: ;
        endcase

        // Restart abandons any fetch in flight but keeps the visible window.
        if (restart) begin
            pos_d          = '0;
            rom_addr_d     = '0;
            div_d          = '0;
            idx_d          = '0;
            init_pending_d = 1'b1;
            window_d       = window_q;
            window_valid_d = window_valid_q;
            step_done_d    = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q          <= '0;
            rom_addr_q     <= '0;
            div_q          <= '0;
            idx_q          <= '0;
            init_pending_q <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) staging_q[i] <= CODE_W'(RESET_CODE);
            window_q       <= WINDOW_RESET;
            window_valid_q <= 1'b0;
            step_done_q    <= 1'b0;
        end else begin
            pos_q          <= pos_d;
            rom_addr_q     <= rom_addr_d;
            div_q          <= div_d;
            idx_q          <= idx_d;
            init_pending_q <= init_pending_d;
            staging_q      <= staging_d;
            window_q       <= window_d;
            window_valid_q <= window_valid_d;
            step_done_q    <= step_done_d;
        end
    end

    // Outputs.
    always_comb begin
        busy         = (state_q != S_IDLE);
        rom_addr     = rom_addr_q;
        window       = window_q;
        window_valid = window_valid_q;
        step_done    = step_done_q;
    end

endmodule

// File: tb/tb_text_window_scroller.sv
// Directed bench for text_window_scroller with STEP_CYCLES=8 and a 12-entry ROM.
module tb_text_window_scroller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        restart;
    logic [3:0]  char_code;
    logic [3:0]  rom_addr;
    logic [15:0] window;
    logic        window_valid;
    logic        busy;
    logic        step_done;

    int total = 0;
    int bad   = 0;

    logic [3:0]  rom_mem [16];
    logic [15:0] exp_win [12];
    logic [3:0]  max_addr = '0;

    text_window_scroller #(
        .MSG_LEN(12), .NUM_DIGITS(4), .STEP_CYCLES(8),
        .ADDR_W(4), .CODE_W(4), .RESET_CODE(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .char_code(char_code), .rom_addr(rom_addr), .window(window),
        .window_valid(window_valid), .busy(busy), .step_done(step_done)
    );

    always #5 clk = ~clk;

    assign char_code = rom_mem[rom_addr];

    always @(negedge clk) if (rst_n && rom_addr > max_addr) max_addr <= rom_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until step_done is seen (bounded); n = edges taken.
    task automatic wait_commit(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!step_done && n < 40);
        chk("commit_seen", step_done, 1);
    endtask

    int n;
    int sd_cnt;

    initial begin
        logic [3:0] rv [12] = '{14, 13, 2, 4, 15, 10, 11, 12, 15, 0, 8, 7};
        for (int i = 0; i < 16; i++) rom_mem[i] = (i < 12) ? rv[i] : 4'h0;
        exp_win = '{16'hED24, 16'hD24F, 16'h24FA, 16'h4FAB, 16'hFABC, 16'hABCF,
                    16'hBCF0, 16'hCF08, 16'hF087, 16'h087E, 16'h87ED, 16'h7ED2};

        rst_n = 1'b0; en = 1'b0; restart = 1'b0;
        #12;
        chk("rst_window", window, 16'hFFFF);
        chk("rst_valid", window_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step_done", step_done, 0);
        chk("rst_rom_addr", rom_addr, 0);

        tick(); rst_n = 1'b1;
        tick(); tick(); tick();
        chk("idle_no_en_busy", busy, 0);
        chk("idle_no_en_valid", window_valid, 0);

        // First fill: trigger edge, 4 fetches, commit on the 5th edge after.
        en = 1'b1;
        tick(); chk("fill_addr0", rom_addr, 0); chk("fill_busy", busy, 1);
        tick(); chk("fill_addr1", rom_addr, 1);
        tick(); chk("fill_addr2", rom_addr, 2);
        tick(); chk("fill_addr3", rom_addr, 3);
        tick(); chk("fill_atomic", window, 16'hFFFF); chk("fill_no_valid", window_valid, 0);
        tick();
        chk("fill_window", window, 16'hED24);
        chk("fill_step_done", step_done, 1);
        chk("fill_valid", window_valid, 1);
        tick();
        chk("pulse_one_cycle", step_done, 0);
        chk("valid_stays", window_valid, 1);

        // Steady scrolling through the wrap back to position 0.
        for (int k = 1; k <= 12; k++) begin
            wait_commit(n);
            chk($sformatf("interval_%0d", k), n, (k == 1) ? 7 : 8);
            chk($sformatf("window_%0d", k), window, exp_win[k % 12]);
        end

        // Freeze with en low: divider is at 5 after commit, 6 after one more edge.
        tick();
        en = 1'b0;
        sd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_done) sd_cnt++;
        end
        chk("freeze_no_step", sd_cnt, 0);
        chk("freeze_window", window, 16'hED24);
        chk("freeze_busy", busy, 0);
        en = 1'b1;
        wait_commit(n);
        chk("resume_latency", n, 7);
        chk("resume_window", window, 16'hD24F);

        for (int k = 2; k <= 5; k++) begin
            wait_commit(n);
            chk($sformatf("pre_restart_%0d", k), window, exp_win[k]);
        end

        // Restart during the pos=6 fetch.
        tick(); tick(); tick(); tick();
        chk("restart_in_fetch", busy, 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_busy", busy, 0);
        chk("restart_window_held", window, 16'hABCF);
        chk("restart_valid_held", window_valid, 1);
        chk("restart_rom_addr", rom_addr, 0);
        chk("restart_no_step", step_done, 0);
        wait_commit(n);
        chk("restart_latency", n, 6);
        chk("restart_window", window, 16'hED24);

        // Async reset in the middle of a fetch.
        tick(); tick(); tick(); tick();
        chk("reset_in_fetch", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_window", window, 16'hFFFF);
        chk("async_valid", window_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_rom_addr", rom_addr, 0);
        tick(); tick();
        rst_n = 1'b1;
        wait_commit(n);
        chk("refill_latency", n, 6);
        chk("refill_window", window, 16'hED24);
        chk("refill_valid", window_valid, 1);

        chk("rom_addr_max", max_addr, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
